// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the 8N1 UART receiver: received byte, status pulses and the pop strobe.
// The receiver drives the master modport; the consuming logic uses the slave modport.
interface uart_rx_if;
  logic [7:0] data;
  logic       dataValid;
  logic       dataRead;
  logic       framingError;
  logic       overrun;
  logic       busy;

  modport master (
    output data,
    output dataValid,
    output framingError,
    output overrun,
    output busy,
    input  dataRead
  );

  modport slave (
    input  data,
    input  dataValid,
    input  framingError,
    input  overrun,
    input  busy,
    output dataRead
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling from a fractional accumulator, 2-FF input synchroniser,
// 3-sample majority vote per bit, start/stop validation and a one-entry output buffer.
module uart_rx #(
  parameter int unsigned CLK_FREQ           = 50000000,
  parameter int unsigned BAUD               = 9600,
  parameter int unsigned BAUD_GEN_ACC_WIDTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  uart_rx_if.master  bus
);

  localparam int unsigned W = BAUD_GEN_ACC_WIDTH;
  // round(BAUD*16*2^W / CLK_FREQ), evaluated in 64 bits to avoid overflow.
  localparam logic [63:0] INC_WIDE =
    ((64'(BAUD) << (W + 4)) + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ);
  localparam logic [W:0] BAUD_GEN_INC = INC_WIDE[W:0];

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [W:0] acc_q, acc_d;
  logic [1:0] sync_q, sync_d;
  logic [2:0] state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] samp_q, samp_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       data_valid_q, data_valid_d;
  logic       framing_error_q, framing_error_d;
  logic       overrun_q, overrun_d;

  logic tick;
  logic rxs;
  logic vote_now;
  logic wrap;
  logic vote;

  assign tick     = acc_q[W];
  assign rxs      = sync_q[1];
  assign vote_now = tick && (tick_cnt_q == 4'd9);
  assign wrap     = tick && (tick_cnt_q == 4'd15);
  assign vote     = majority3(samp_q[0], samp_q[1], rxs);

  always_comb begin
    acc_d           = {1'b0, acc_q[W-1:0]} + BAUD_GEN_INC;
    sync_d          = {sync_q[0], rx};
    state_d         = state_q;
    tick_cnt_d      = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    samp_d          = samp_q;
    shift_d         = shift_q;
    data_d          = data_q;
    data_valid_d    = data_valid_q & ~bus.dataRead;
    framing_error_d = 1'b0;
    overrun_d       = 1'b0;

    // Mid-bit samples on ticks 7 and 8; the third sample is rxs itself at tick 9.
    if (tick && (tick_cnt_q == 4'd7)) samp_d[0] = rxs;
    if (tick && (tick_cnt_q == 4'd8)) samp_d[1] = rxs;

    case (state_q)
      ST_IDLE: begin
        tick_cnt_d = 4'd0;
        bit_cnt_d  = 3'd0;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        if (vote_now && vote) begin
          state_d = ST_IDLE;
        end else if (wrap) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (vote_now) shift_d = {vote, shift_q[7:1]};
        if (wrap) begin
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      ST_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (vote_now) begin
          if (vote) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
            overrun_d    = data_valid_q & ~bus.dataRead;
            state_d      = ST_IDLE;
          end else begin
            framing_error_d = 1'b1;
            state_d         = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q           <= '0;
      sync_q          <= 2'b11;
      state_q         <= ST_IDLE;
      tick_cnt_q      <= 4'd0;
      bit_cnt_q       <= 3'd0;
      samp_q          <= 2'b11;
      shift_q         <= 8'd0;
      data_q          <= 8'd0;
      data_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      acc_q           <= acc_d;
      sync_q          <= sync_d;
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      samp_q          <= samp_d;
      shift_q         <= shift_d;
      data_q          <= data_d;
      data_valid_q    <= data_valid_d;
      framing_error_q <= framing_error_d;
      overrun_q       <= overrun_d;
    end
  end

  assign bus.data         = data_q;
  assign bus.dataValid    = data_valid_q;
  assign bus.framingError = framing_error_q;
  assign bus.overrun      = overrun_q;
  assign bus.busy         = (state_q != ST_IDLE);

endmodule
